// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, special instruction
// encodings and the fetch-stage state encoding used by decode and hazard logic.
package mips_pkg;

  localparam int NB_DATA = 32;

  localparam logic [NB_DATA-1:0] NOP        = 32'h0000_0000;
  localparam logic [NB_DATA-1:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: one synchronous write port for program
// loading and one combinational read port for fetch.
module instruction_memory #(
  parameter  int NB_DATA   = 32,
  parameter  int MEM_DEPTH = 256,
  localparam int NB_ADDR   = $clog2(MEM_DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [NB_ADDR-1:0] waddr,
  input  logic [NB_DATA-1:0] wdata,
  input  logic [NB_ADDR-1:0] raddr,
  output logic [NB_DATA-1:0] rdata
);

  logic [NB_DATA-1:0] mem [MEM_DEPTH];

  // NOTE: the array has no reset on purpose; a loaded program must survive a
  // pipeline reset, and a resettable array would not map onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: program counter, fetch FSM (IDLE/RUN/HALT) and the IF/ID
// pipeline register, with redirect, flush, stall and program-load support.
module instruction_fetch #(
  parameter int                 NB_DATA    = mips_pkg::NB_DATA,
  parameter int                 MEM_DEPTH  = 256,
  parameter logic [NB_DATA-1:0] HALT_INSTR = mips_pkg::HALT_INSTR
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_pc_sel,
  input  logic [NB_DATA-1:0] i_pc_target,
  input  logic               i_load_we,
  input  logic [NB_DATA-1:0] i_load_addr,
  input  logic [NB_DATA-1:0] i_load_data,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pcounter4,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_halt
);

  import mips_pkg::*;

  localparam int NB_ADDR = $clog2(MEM_DEPTH);
  localparam logic [NB_DATA-1:0] PC_STEP = NB_DATA'(4);

  fetch_state_t       state_q, state_d;
  logic [NB_DATA-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic [NB_DATA-1:0] pc4_q, pc4_d;
  logic               valid_q, valid_d;

  logic [NB_DATA-1:0] mem_rdata;
  logic [NB_DATA-1:0] pc_plus4;
  logic               fetch_hold;
  logic               fetch_is_halt;
  logic               load_en;

  assign pc_plus4      = pc_q + PC_STEP;
  assign fetch_hold    = i_stall || !i_enable;
  assign fetch_is_halt = (mem_rdata == HALT_INSTR);
  assign load_en       = i_load_we && (state_q == IDLE);

  // Only the word-index bits of the load address reach the memory.
  logic unused_load_addr;
  assign unused_load_addr = ^{i_load_addr[NB_DATA-1:NB_ADDR+2], i_load_addr[1:0]};

  instruction_memory #(
    .NB_DATA  (NB_DATA),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_imem (
    .clk  (clk),
    .we   (load_en),
    .waddr(i_load_addr[NB_ADDR+1:2]),
    .wdata(i_load_data),
    .raddr(pc_q[NB_ADDR+1:2]),
    .rdata(mem_rdata)
  );

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (i_enable && !i_load_we) state_d = RUN;
      RUN:  if (!i_pc_sel && !i_flush && !fetch_hold && fetch_is_halt) state_d = HALT;
      HALT: if (i_pc_sel) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Redirect and flush outrank stall: a wrong-path instruction is never held.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    unique case (state_q)
      RUN: begin
        if (i_pc_sel || i_flush) begin
          pc_d    = i_pc_sel ? i_pc_target : pc_plus4;
          instr_d = NOP;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else if (!fetch_hold) begin
          instr_d = mem_rdata;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          if (!fetch_is_halt) pc_d = pc_plus4;
        end
      end
      HALT: begin
        if (i_pc_sel) pc_d = i_pc_target;
        instr_d = NOP;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
      default: begin
        pc_d    = '0;
        instr_d = NOP;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      pc_q    <= '0;
      instr_q <= NOP;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_instruction = instr_q;
  assign o_pcounter4   = pc4_q;
  assign o_valid       = valid_q;
  assign o_halt        = (state_q == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a behavioural fetch model is
// compared every cycle, and directed scenarios pin literal expected values.
module tb_instruction_fetch;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, enable, stall, flush, pc_sel, load_we;
  logic [31:0] pc_target, load_addr, load_data;
  logic [31:0] o_instruction, o_pcounter4, o_pc;
  logic        o_valid, o_halt;

  always #5 clk = ~clk;

  instruction_fetch #(
    .NB_DATA   (32),
    .MEM_DEPTH (256),
    .HALT_INSTR(32'hFFFF_FFFF)
  ) dut (
    .clk          (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_pc_sel     (pc_sel),
    .i_pc_target  (pc_target),
    .i_load_we    (load_we),
    .i_load_addr  (load_addr),
    .i_load_data  (load_data),
    .o_instruction(o_instruction),
    .o_pcounter4  (o_pcounter4),
    .o_valid      (o_valid),
    .o_pc         (o_pc),
    .o_halt       (o_halt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a word array plus the architectural fetch rules.
  typedef enum {M_IDLE, M_RUN, M_HALT} mstate_t;
  mstate_t     m_state = M_IDLE;
  logic [31:0] m_mem [256];
  logic [31:0] m_pc = '0, m_ins = '0, m_pc4 = '0;
  logic        m_val = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_state <= M_IDLE;
      m_pc <= '0; m_ins <= '0; m_pc4 <= '0; m_val <= 1'b0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (load_we) m_mem[load_addr[9:2]] <= load_data;
          if (enable && !load_we) m_state <= M_RUN;
        end
        M_RUN: begin
          if (pc_sel) begin
            m_pc <= pc_target; m_ins <= '0; m_pc4 <= '0; m_val <= 1'b0;
          end else if (flush) begin
            m_pc <= m_pc + 32'd4; m_ins <= '0; m_pc4 <= '0; m_val <= 1'b0;
          end else if (enable && !stall) begin
            m_ins <= m_mem[m_pc[9:2]];
            m_pc4 <= m_pc + 32'd4;
            m_val <= 1'b1;
            if (m_mem[m_pc[9:2]] === HALT_W) m_state <= M_HALT;
            else m_pc <= m_pc + 32'd4;
          end
        end
        default: begin
          m_ins <= '0; m_pc4 <= '0; m_val <= 1'b0;
          if (pc_sel) begin
            m_pc <= pc_target; m_state <= M_RUN;
          end
        end
      endcase
    end
  end

  bit cmp_en = 1'b0;

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("model_pc",    o_pc,          m_pc);
      check("model_instr", o_instruction, m_ins);
      check("model_pc4",   o_pcounter4,   m_pc4);
      check("model_valid", {31'b0, o_valid}, {31'b0, m_val});
      check("model_halt",  {31'b0, o_halt},  {31'b0, m_state == M_HALT});
    end
  end

  // Advance n edges, then settle 2 time units past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    load_we = 1'b1; load_addr = addr; load_data = data;
    cyc(1);
    load_we = 1'b0;
  endtask

  task automatic expect_ifid(input string name, input logic [31:0] ins, input logic [31:0] pc4,
                             input logic val, input logic [31:0] pc, input logic halt);
    check({name, "_instr"}, o_instruction, ins);
    check({name, "_pc4"},   o_pcounter4,   pc4);
    check({name, "_valid"}, {31'b0, o_valid}, {31'b0, val});
    check({name, "_pc"},    o_pc,          pc);
    check({name, "_halt"},  {31'b0, o_halt},  {31'b0, halt});
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; stall = 1'b0; flush = 1'b0; pc_sel = 1'b0;
    load_we = 1'b0; pc_target = '0; load_addr = '0; load_data = '0;
    cyc(2);
    cmp_en = 1'b1;
    expect_ifid("reset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;

    // Program A: two ADDIs then HALT.
    load(32'h0, 32'h2008_0005);
    load(32'h4, 32'h2009_0003);
    load(32'h8, HALT_W);
    // enable together with a load keeps the FSM in IDLE
    enable = 1'b1; load_we = 1'b1; load_addr = 32'hC; load_data = 32'h1000_000C;
    cyc(1);
    load_we = 1'b0;
    expect_ifid("idle_load_en", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc(1);
    expect_ifid("run_entry", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc(1);
    expect_ifid("fetch0", 32'h2008_0005, 32'h4, 1'b1, 32'h4, 1'b0);
    cyc(1);
    expect_ifid("fetch1", 32'h2009_0003, 32'h8, 1'b1, 32'h8, 1'b0);
    cyc(1);
    expect_ifid("fetch_halt", HALT_W, 32'hC, 1'b1, 32'h8, 1'b1);
    stall = 1'b1; flush = 1'b1;
    cyc(1);
    stall = 1'b0; flush = 1'b0;
    expect_ifid("halt_ignore", 32'h0, 32'h0, 1'b0, 32'h8, 1'b1);
    cyc(1);

    // Program B: word at address a holds 0x1000_0000|a, HALT at 0x44.
    rst = 1'b1; enable = 1'b0;
    cyc(1);
    rst = 1'b0;
    for (int a = 0; a < 'h50; a += 4)
      load(32'(a), (a == 'h44) ? HALT_W : (32'h1000_0000 | 32'(a)));
    load(32'hFFFF_FFFC, 32'h1000_03FC);
    enable = 1'b1;
    cyc(5);
    expect_ifid("run_to_10", 32'h1000_000C, 32'h10, 1'b1, 32'h10, 1'b0);
    stall = 1'b1;
    cyc(3);
    stall = 1'b0;
    expect_ifid("stall3", 32'h1000_000C, 32'h10, 1'b1, 32'h10, 1'b0);
    cyc(1);
    expect_ifid("resume", 32'h1000_0010, 32'h14, 1'b1, 32'h14, 1'b0);
    enable = 1'b0;
    cyc(2);
    enable = 1'b1;
    expect_ifid("disabled", 32'h1000_0010, 32'h14, 1'b1, 32'h14, 1'b0);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    expect_ifid("flush", 32'h0, 32'h0, 1'b0, 32'h18, 1'b0);
    pc_sel = 1'b1; pc_target = 32'h10;
    cyc(1);
    pc_target = 32'h40; stall = 1'b1;
    cyc(1);
    pc_sel = 1'b0; stall = 1'b0;
    expect_ifid("redir_stall", 32'h0, 32'h0, 1'b0, 32'h40, 1'b0);
    cyc(1);
    expect_ifid("target_40", 32'h1000_0040, 32'h44, 1'b1, 32'h44, 1'b0);
    cyc(1);
    expect_ifid("wrong_halt", HALT_W, 32'h48, 1'b1, 32'h44, 1'b1);
    pc_sel = 1'b1; pc_target = 32'h20;
    cyc(1);
    pc_sel = 1'b0;
    expect_ifid("halt_redir", 32'h0, 32'h0, 1'b0, 32'h20, 1'b0);
    cyc(1);
    expect_ifid("target_20", 32'h1000_0020, 32'h24, 1'b1, 32'h24, 1'b0);
    pc_sel = 1'b1; pc_target = 32'h404;
    cyc(1);
    pc_sel = 1'b0;
    cyc(1);
    expect_ifid("index_wrap", 32'h1000_0004, 32'h408, 1'b1, 32'h408, 1'b0);
    pc_sel = 1'b1; pc_target = 32'hFFFF_FFFC;
    cyc(1);
    pc_sel = 1'b0;
    cyc(1);
    expect_ifid("pc_wrap", 32'h1000_03FC, 32'h0, 1'b1, 32'h0, 1'b0);

    // Load attempt in RUN must not reach memory.
    load_we = 1'b1; load_addr = 32'h0; load_data = 32'hDEAD_BEEF;
    pc_sel = 1'b1; pc_target = 32'h18;
    cyc(1);
    pc_sel = 1'b0;
    cyc(1);
    load_we = 1'b0;
    expect_ifid("pc_1c", 32'h1000_0018, 32'h1C, 1'b1, 32'h1C, 1'b0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    expect_ifid("mid_reset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc(2);
    expect_ifid("refetch0", 32'h1000_0000, 32'h4, 1'b1, 32'h4, 1'b0);
    cyc(1);

    cmp_en = 1'b0;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
